// File: rtl/window_pattern_detector.sv
// window_pattern_detector
// Sliding-window detector over a 1-bit serial stream. The last WINDOW samples
// are kept in a shift register (bit 0 = newest). A running ones count is
// maintained incrementally so that the threshold compares need no popcount
// tree. A hit is qualified by a full window and is then either
// kept overlapping (window keeps sliding) or used to restart the window.
// A saturating event counter accumulates hits.
module window_pattern_detector #(
    parameter  int WINDOW = 3,
    parameter  int EVT_W  = 16,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              serial_pattern_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  threshold_i,
    input  logic [WINDOW-1:0] pattern_i,
    input  logic [WINDOW-1:0] mask_i,
    input  logic              non_overlap_i,
    input  logic              clear_count_i,
    output logic              pattern_detected_o,
    output logic [CNT_W-1:0]  ones_count_o,
    output logic              window_full_o,
    output logic [EVT_W-1:0]  event_count_o
);

    // Detector condition encodings on mode_i.
    localparam logic [1:0] MODE_EXACT    = 2'b00;
    localparam logic [1:0] MODE_AT_LEAST = 2'b01;
    localparam logic [1:0] MODE_AT_MOST  = 2'b10;
    localparam logic [1:0] MODE_MATCH    = 2'b11;

    localparam logic [CNT_W-1:0] FILL_FULL_C = CNT_W'(WINDOW);
    localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX_C   = {EVT_W{1'b1}};
    localparam logic [EVT_W-1:0] EVT_ONE_C   = EVT_W'(1);

    // IDLE: flushed, FILL: collecting samples, ARMED: window full and sliding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t              state_r;
    logic [WINDOW-1:0]   hist_r;
    logic [CNT_W-1:0]    fill_r;
    logic [CNT_W-1:0]    ones_r;
    logic                pattern_detected_r;
    logic                window_full_r;
    logic [EVT_W-1:0]    event_count_r;

    logic [WINDOW-1:0]   hist_n_s;
    logic [CNT_W-1:0]    fill_n_s;
    logic [CNT_W-1:0]    ones_n_s;
    logic                full_now_s;
    logic                full_n_s;
    logic                oldest_s;
    logic                cond_s;
    logic                hit_s;
    logic                restart_s;
    logic [EVT_W-1:0]    event_count_n_s;

    // Next window contents, ones count and fill level for a sample taken this cycle.
    always_comb begin
        hist_n_s   = {hist_r[WINDOW-2:0], serial_pattern_i};
        // ARMED is held exactly while the fill counter sits at WINDOW, so the
        // state doubles as the "oldest bit is about to drop out" flag.
        full_now_s = (state_r == ST_ARMED);
        if (full_now_s) begin
            oldest_s = hist_r[WINDOW-1];
            fill_n_s = FILL_FULL_C;
        end else begin
            oldest_s = 1'b0;
            fill_n_s = fill_r + CNT_ONE_C;
        end
        // Modular arithmetic is safe here: the true result always lies in 0..WINDOW.
        ones_n_s = ones_r + CNT_W'(serial_pattern_i) - CNT_W'(oldest_s);
        full_n_s = (fill_n_s == FILL_FULL_C);
    end

    // Runtime-selected hit condition evaluated on the post-sample window.
    always_comb begin
        case (mode_i)
            MODE_EXACT:    cond_s = (ones_n_s == threshold_i);
            MODE_AT_LEAST: cond_s = (ones_n_s >= threshold_i);
            MODE_AT_MOST:  cond_s = (ones_n_s <= threshold_i);
            MODE_MATCH:    cond_s = (((hist_n_s ^ pattern_i) & mask_i) == {WINDOW{1'b0}});
            default:       cond_s = 1'b0;
        endcase
        hit_s     = enable_i & full_n_s & cond_s;
        restart_s = hit_s & non_overlap_i;
    end

    // Saturating hit counter; a clear coinciding with a hit leaves the new hit counted.
    always_comb begin
        if (clear_count_i) begin
            if (hit_s) begin
                event_count_n_s = EVT_ONE_C;
            end else begin
                event_count_n_s = {EVT_W{1'b0}};
            end
        end else if (hit_s && (event_count_r != EVT_MAX_C)) begin
            event_count_n_s = event_count_r + EVT_ONE_C;
        end else begin
            event_count_n_s = event_count_r;
        end
    end

    // Control FSM with window state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= ST_IDLE;
            hist_r             <= {WINDOW{1'b0}};
            fill_r             <= {CNT_W{1'b0}};
            ones_r             <= {CNT_W{1'b0}};
            pattern_detected_r <= 1'b0;
            window_full_r      <= 1'b0;
            event_count_r      <= {EVT_W{1'b0}};
        end else begin
            event_count_r <= event_count_n_s;
            if (!enable_i) begin
                // Flush: the next hit needs WINDOW fresh samples.
                state_r            <= ST_IDLE;
                hist_r             <= {WINDOW{1'b0}};
                fill_r             <= {CNT_W{1'b0}};
                ones_r             <= {CNT_W{1'b0}};
                pattern_detected_r <= 1'b0;
                window_full_r      <= 1'b0;
            end else begin
                pattern_detected_r <= hit_s;
                case (state_r)
                    ST_IDLE, ST_FILL, ST_ARMED: begin
                        if (restart_s) begin
                            state_r       <= ST_FILL;
                            hist_r        <= {WINDOW{1'b0}};
                            fill_r        <= {CNT_W{1'b0}};
                            ones_r        <= {CNT_W{1'b0}};
                            window_full_r <= 1'b0;
                        end else begin
                            state_r       <= full_n_s ? ST_ARMED : ST_FILL;
                            hist_r        <= hist_n_s;
                            fill_r        <= fill_n_s;
                            ones_r        <= ones_n_s;
                            window_full_r <= full_n_s;
                        end
                    end
                    default: begin
                        // Unreachable encoding: recover to a clean flushed state.
                        state_r       <= ST_IDLE;
                        hist_r        <= {WINDOW{1'b0}};
                        fill_r        <= {CNT_W{1'b0}};
                        ones_r        <= {CNT_W{1'b0}};
                        window_full_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pattern_detected_o = pattern_detected_r;
    assign ones_count_o       = ones_r;
    assign window_full_o      = window_full_r;
    assign event_count_o      = event_count_r;

endmodule

// File: tb/tb_window_pattern_detector.sv
// Self-checking bench for window_pattern_detector: directed scenarios with
// hand-computed expectations plus a long random run against a queue-based
// reference model.
module tb_window_pattern_detector;

    localparam int W  = 3;
    localparam int CW = $clog2(W + 1);
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic          serial_pattern_i;
    logic [1:0]    mode_i;
    logic [CW-1:0] threshold_i;
    logic [W-1:0]  pattern_i;
    logic [W-1:0]  mask_i;
    logic          non_overlap_i;
    logic          clear_count_i;
    logic          pattern_detected_o;
    logic [CW-1:0] ones_count_o;
    logic          window_full_o;
    logic [EW-1:0] event_count_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples since the last restart, oldest first.
    bit q[$];
    bit m_hit;
    int m_cnt;
    int m_ones;
    bit m_full;

    always #5 clk = ~clk;

    window_pattern_detector #(.WINDOW(W), .EVT_W(EW)) dut (
        .clk                (clk),
        .rst                (rst),
        .enable_i           (enable_i),
        .serial_pattern_i   (serial_pattern_i),
        .mode_i             (mode_i),
        .threshold_i        (threshold_i),
        .pattern_i          (pattern_i),
        .mask_i             (mask_i),
        .non_overlap_i      (non_overlap_i),
        .clear_count_i      (clear_count_i),
        .pattern_detected_o (pattern_detected_o),
        .ones_count_o       (ones_count_o),
        .window_full_o      (window_full_o),
        .event_count_o      (event_count_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply the rules to the inputs consumed on the edge that just occurred.
    function automatic void model_step();
        bit hit;
        int ones;
        int thr;
        logic [W-1:0] win;
        hit = 1'b0;
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (!enable_i) begin
                q.delete();
            end else begin
                q.push_back(serial_pattern_i);
                if (q.size() > W) void'(q.pop_front());
                if (q.size() == W) begin
                    ones = 0;
                    thr  = int'(threshold_i);
                    for (int i = 0; i < W; i++) begin
                        ones += int'(q[i]);
                        win[W-1-i] = q[i];
                    end
                    case (mode_i)
                        2'd0:    hit = (ones == thr);
                        2'd1:    hit = (ones >= thr);
                        2'd2:    hit = (ones <= thr);
                        default: hit = (((win ^ pattern_i) & mask_i) == '0);
                    endcase
                    if (hit && non_overlap_i) q.delete();
                end
            end
            if (clear_count_i) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < (1 << EW) - 1) m_cnt++;
        end
        m_hit  = hit;
        m_ones = 0;
        foreach (q[i]) m_ones += int'(q[i]);
        m_full = (q.size() == W);
    endfunction

    // One clock: update the model on the edge, then compare every output.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("pattern_detected", pattern_detected_o, m_hit);
        chk("ones_count",       ones_count_o,       m_ones);
        chk("window_full",      window_full_o,      m_full);
        chk("event_count",      event_count_o,      m_cnt);
    endtask

    task automatic drive(input bit en, input bit s, input bit clr);
        rst = 1'b0; enable_i = en; serial_pattern_i = s; clear_count_i = clr;
        cycle();
    endtask

    task automatic flush_clear();
        drive(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bit t1_s[6];
        bit t1_hit[6];
        int t1_ones[6];
        bit t2_hit[6];
        bit t3_s[5];
        bit t3_hit[5];

        t1_s    = '{1, 1, 0, 1, 1, 1};
        t1_hit  = '{0, 0, 1, 1, 1, 0};
        t1_ones = '{1, 2, 2, 2, 2, 3};
        t2_hit  = '{0, 0, 1, 0, 0, 0};
        t3_s    = '{1, 0, 1, 0, 1};
        t3_hit  = '{0, 0, 1, 0, 1};

        rst = 1'b1; enable_i = 1'b1; serial_pattern_i = 1'b1; clear_count_i = 1'b0;
        mode_i = 2'd0; threshold_i = CW'(2); pattern_i = '0; mask_i = '0; non_overlap_i = 1'b0;
        cycle();
        cycle();
        chk("reset_hit", pattern_detected_o, 0);
        chk("reset_evt", event_count_o, 0);
        chk("reset_full", window_full_o, 0);

        // EXACT 2, overlapping windows.
        flush_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, t1_s[i], 1'b0);
            chk("t1_hit_lit", pattern_detected_o, t1_hit[i]);
            chk("t1_ones_lit", ones_count_o, t1_ones[i]);
        end
        chk("t1_evt_lit", event_count_o, 3);

        // Same stream, non-overlapping.
        non_overlap_i = 1'b1;
        flush_clear();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, t1_s[i], 1'b0);
            chk("t2_hit_lit", pattern_detected_o, t2_hit[i]);
            if (i == 2) chk("t2_full_after_hit", window_full_o, 0);
        end
        chk("t2_full_lit", window_full_o, 1);
        chk("t2_evt_lit", event_count_o, 1);
        non_overlap_i = 1'b0;

        // MATCH 101 then unmasked.
        mode_i = 2'd3; pattern_i = 3'b101; mask_i = 3'b111;
        flush_clear();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, t3_s[i], 1'b0);
            chk("t3_hit_lit", pattern_detected_o, t3_hit[i]);
        end
        mask_i = 3'b000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i[0], 1'b0);
            chk("t3_mask0_lit", pattern_detected_o, 1);
        end

        // Enable drop breaks the window.
        mode_i = 2'd0; threshold_i = CW'(2);
        flush_clear();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        chk("t4_flush_full", window_full_o, 0);
        drive(1'b1, 1'b0, 1'b0);
        chk("t4_nohit_a", pattern_detected_o, 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("t4_nohit_b", pattern_detected_o, 0);
        drive(1'b1, 1'b1, 1'b0);
        chk("t4_hit_lit", pattern_detected_o, 1);

        // Saturation and clear with a concurrent hit.
        mode_i = 2'd2; threshold_i = CW'(3);
        flush_clear();
        for (int i = 0; i < 22; i++) drive(1'b1, 1'(i % 3 == 0), 1'b0);
        chk("t5_sat_lit", event_count_o, 15);
        drive(1'b1, 1'b0, 1'b1);
        chk("t5_clr_hit_lit", event_count_o, 1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        chk("t5_clr_only_lit", event_count_o, 0);

        // Reset while ARMED with a hit pending.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
        rst = 1'b1; enable_i = 1'b1; clear_count_i = 1'b1;
        cycle();
        chk("t6_rst_hit", pattern_detected_o, 0);
        chk("t6_rst_ones", ones_count_o, 0);
        chk("t6_rst_full", window_full_o, 0);
        chk("t6_rst_evt", event_count_o, 0);

        // Random run across all modes and policies.
        for (int n = 0; n < 10000; n++) begin
            rst              = ($urandom_range(199) == 0);
            enable_i         = ($urandom_range(19) != 0);
            serial_pattern_i = 1'($urandom);
            clear_count_i    = ($urandom_range(29) == 0);
            mode_i           = 2'($urandom);
            threshold_i      = CW'($urandom);
            pattern_i        = W'($urandom);
            mask_i           = ($urandom_range(7) == 0) ? '0 : W'($urandom);
            non_overlap_i    = ($urandom_range(3) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/window_pattern_detector.md
# window_pattern_detector

Parametrised serial pattern detector: inspects a sliding window of the last WINDOW bits of a 1-bit serial stream and flags a hit when a runtime-selected condition holds. Condition is a ones-count compare (exact, at-least, at-most) or a masked bit-pattern match. Adds an overlap/non-overlap policy, a fill qualifier and a saturating hit counter. Sits in the serial front end as a configurable replacement for fixed-function "k of last n" detectors.

## Interface
- WINDOW, 3, window length in bits, legal 2..32
- CNT_W, $clog2(WINDOW+1), derived (localparam), width of ones count and threshold
- EVT_W, 16, width of hit counter
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable_i  input  1  sample serial_pattern_i this cycle; low = flush
- serial_pattern_i  input  1  serial data bit
- mode_i  input  2  00 EXACT, 01 AT_LEAST, 10 AT_MOST, 11 MATCH
- threshold_i  input  CNT_W  ones-count threshold (modes 00-10)
- pattern_i  input  WINDOW  match pattern (mode 11), bit 0 = newest sample
- mask_i  input  WINDOW  1 = bit compared (mode 11)
- non_overlap_i  input  1  1 = window restarts after every hit
- clear_count_i  input  1  zero the hit counter
- pattern_detected_o  output  1  registered hit flag
- ones_count_o  output  CNT_W  ones currently in the window
- window_full_o  output  1  WINDOW samples held since last restart
- event_count_o  output  EVT_W  saturating hit count

## Operation
- State: hist[WINDOW-1:0] (bit 0 newest), fill counter 0..WINDOW, ones counter, FSM {IDLE, FILL, ARMED}.
- IDLE: enable_i low. hist, fill, ones cleared; pattern_detected_o <= 0; event_count_o held. enable_i high -> FILL, and that same cycle's bit is sampled.
- Sample cycle (enable_i=1): hist_n = {hist[WINDOW-2:0], serial}; ones_n = ones + serial - (fill==WINDOW ? hist[WINDOW-1] : 0); fill_n = min(fill+1, WINDOW).
- FILL -> ARMED when fill_n==WINDOW. No hit possible before the window is full.
- hit = (fill_n==WINDOW) && cond(hist_n, ones_n):
  - EXACT: ones_n == threshold_i.
  - AT_LEAST: ones_n >= threshold_i.
  - AT_MOST: ones_n <= threshold_i.
  - MATCH: ((hist_n ^ pattern_i) & mask_i) == 0.
  - mask_i=0 in MATCH: every full window hits.
  - threshold_i > WINDOW: EXACT/AT_LEAST never hit; AT_MOST always hits.
- non_overlap_i=1 and hit: hist, fill and ones load 0 instead of the _n values; FSM -> FILL.
- Otherwise hist, fill and ones load the _n values. ARMED persists with overlapping windows.
- Config inputs (mode_i, threshold_i, pattern_i, mask_i, non_overlap_i) are used combinationally at each sample. They are not latched, and a change applies from the next sample.
- event_count_o:
  - increments by 1 per hit and saturates at 2^EVT_W-1.
  - clear_count_i alone -> 0.
  - clear_count_i with a hit in the same cycle -> 1.
- Ones counter is incremental; it must always equal popcount(hist). Bench checks this every cycle.

## Timing
- Reset: all outputs 0, FSM IDLE, hist/fill/ones 0. rst overrides enable_i and clear_count_i.
- Latency: pattern_detected_o, ones_count_o, window_full_o and event_count_o all reflect a sample on the edge that consumes it, visible one cycle later.
- pattern_detected_o is a one-cycle pulse per hit. Back-to-back hits give a continuous high.
- enable_i low for one cycle flushes the window. The next hit needs WINDOW fresh samples.
- rst mid-fill or mid-ARMED: everything is cleared on that edge. The cycle after, all outputs read 0.
- window_full_o drops with the flush/restart edge, including a non-overlap restart.

## Test plan
- WINDOW=3, EXACT, threshold 2, serial 1,1,0,1,1,1 -> pattern_detected_o 0,0,1,1,1,0 (one cycle late); event_count_o ends at 3; ones_count_o 1,2,2,2,2,3.
- Same stimulus, non_overlap_i=1 -> pattern_detected_o 0,0,1,0,0,0; window_full_o low after hit and high again after the 6th sample; event_count_o=1.
- MATCH, pattern 3'b101, mask 3'b111, serial 1,0,1,0,1 -> hits after samples 3 and 5 only. Then mask 3'b000 -> every sample hits.
- Enable drop: serial 1,1 then enable_i low 1 cycle, then 0,1 -> no hit (window not full). The next 1 completes window 011 -> hit in EXACT threshold 2.
- EVT_W=4, AT_MOST threshold 3 (always hit), 20 full samples -> event_count_o=15. clear_count_i with a concurrent hit -> 1.
- rst asserted mid-ARMED while a hit is in progress -> next cycle all outputs 0. Random 10k-sample run vs. a reference model, all modes, checking ones_count_o == popcount.
